// File: rtl/mux_scan_capture.sv
// Scan-capture receiver for a 4:1 strobe-gated mux: steps the select C, samples D, and rebuilds the word on Q.
// Optional build macro MUX_SCAN_MAJORITY_EN replaces the single end-of-slot sample with a majority vote.
module mux_scan_capture #(
    parameter int DWELL = 2,
    parameter int CNT_W = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       G,
    input  logic       D,
    output logic [1:0] C,
    output logic [3:0] Q,
    output logic       VALID,
    output logic       BUSY
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    logic [0:0]       r_state;
    logic [1:0]       r_c;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_shadow;
    logic [3:0]       r_q;
    logic             r_valid;

    logic w_scanning;
    logic w_slot_end;
    logic w_bit;

    assign w_scanning = (r_state == ST_SCAN) && !G;
    assign w_slot_end = !(r_cnt < LAST_CNT);

`ifdef MUX_SCAN_MAJORITY_EN
    // With three or more cycles per slot, the first cycle is skipped because D may still be settling.
    localparam int N_COUNTED = (DWELL >= 3) ? DWELL - 1 : DWELL;

    logic [CNT_W-1:0] r_ones;
    logic             w_count_now;
    logic [CNT_W:0]   w_total;

    assign w_count_now = (DWELL < 3) || (r_cnt != '0);
    assign w_total     = {1'b0, r_ones} + (CNT_W + 1)'(D & w_count_now);
    assign w_bit       = {w_total, 1'b0} > (CNT_W + 2)'(N_COUNTED);

    always_ff @(posedge CLK) begin
        if (RESET || !w_scanning || w_slot_end) begin
            r_ones <= '0;
        end else if (D && w_count_now) begin
            r_ones <= r_ones + 1'b1;
        end
    end
`else
    assign w_bit = D;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_c     <= 2'd0;
            r_cnt   <= '0;
            r_q     <= 4'd0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!G) begin
                        r_state <= ST_SCAN;
                        r_c     <= 2'd0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    if (G) begin
                        // Abort drops the partial frame; Q keeps the last complete word.
                        r_state <= ST_IDLE;
                        r_c     <= 2'd0;
                        r_cnt   <= '0;
                    end else if (!w_slot_end) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt <= '0;
                        r_c   <= r_c + 2'd1;
                        if (r_c == 2'd3) begin
                            r_q     <= {w_bit, r_shadow};
                            r_valid <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Slots 0..2 park their bit here until slot 3 completes the word.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_shadow
            always_ff @(posedge CLK) begin
                if (RESET || (r_state == ST_SCAN && G)) begin
                    r_shadow[gi] <= 1'b0;
                end else if (w_scanning && w_slot_end && r_c == 2'(gi)) begin
                    r_shadow[gi] <= w_bit;
                end
            end
        end
    endgenerate

    assign C     = r_c;
    assign Q     = r_q;
    assign VALID = r_valid;
    assign BUSY  = (r_state == ST_SCAN);

endmodule
